// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and constants for the debounce_pulse block:
//               FSM state encoding, default parameter values and helpers
//               that size the stability and auto-repeat counters.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

   // FSM states; the encoding is exported on the `state` port for debug.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_ARMING    = 2'b01,
      ST_HELD      = 2'b10,
      ST_RELEASING = 2'b11
   } db_state_t;

   // Default parameter values.
   localparam int unsigned c_stable_cycles_def = 4;
   localparam int unsigned c_repeat_delay_def  = 16;
   localparam int unsigned c_repeat_period_def = 4;

   // Width of a counter that must be able to hold the value max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer for an asynchronous input.
//               Both flops clear to 0 while `clear` is low.
// Ports       : clock   - system clock (rising edge)
//               clear   - asynchronous active-low reset
//               async_i - asynchronous input line
//               sync_o  - synchronized copy of async_i (two-cycle delay)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
   input  logic clock,
   input  logic clear,
   input  logic async_i,
   output logic sync_o
);

   logic sync1_q;
   logic sync2_q;

   // First flop may go metastable; only sync2_q is used downstream.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
      end
   end

   assign sync_o = sync2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pulse
// Description : Synchronizes and debounces a raw asynchronous event line and
//               emits a single-cycle `pulse` for each accepted rising event.
//               The debounced level and FSM state are exported for debug.
//               Optional auto-repeat while held: define the macro
//               DEBOUNCE_PULSE_AUTO_REPEAT_EN.
// Ports       : clock  - system clock (rising edge)
//               clear  - asynchronous active-low reset
//               raw_in - raw, possibly bouncing, asynchronous input
//               enable - 0 masks `pulse` only; debouncing carries on
//               pulse  - registered one-cycle pulse per accepted press
//               level  - registered debounced level
//               state  - current FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_pulse
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = c_stable_cycles_def,
   parameter int unsigned REPEAT_DELAY  = c_repeat_delay_def,
   parameter int unsigned REPEAT_PERIOD = c_repeat_period_def
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       raw_in,
   input  logic       enable,
   output logic       pulse,
   output logic       level,
   output logic [1:0] state
);

   localparam int unsigned          c_cnt_w    = cnt_width(STABLE_CYCLES);
   localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks. The repeat parameters are checked in
   // every build so a configuration stays valid when the feature is switched
   // on; a value below 2 would let two pulses land on adjacent cycles.
   // ------------------------------------------------------------------------
   if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 255)) begin : g_chk_stable
      $error("debounce_pulse: STABLE_CYCLES must be in 2..255");
   end
   if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_chk_repeat
      $error("debounce_pulse: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
   end

   // ------------------------------------------------------------------------
   // Synchronizer
   // ------------------------------------------------------------------------
   logic s;

   sync_2ff u_sync (
      .clock   (clock),
      .clear   (clear),
      .async_i (raw_in),
      .sync_o  (s)
   );

   // ------------------------------------------------------------------------
   // FSM state
   // ------------------------------------------------------------------------
   db_state_t          state_q, state_d;
   logic [c_cnt_w-1:0] cnt_q,   cnt_d;
   logic               level_q, level_d;
   logic               pulse_q, pulse_d;
   logic               rpt_fire;

   // ------------------------------------------------------------------------
   // Auto-repeat
   // ------------------------------------------------------------------------
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
   localparam int unsigned            c_rpt_w     = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [c_rpt_w-1:0]     c_rpt_first = c_rpt_w'(REPEAT_DELAY - 1);
   localparam logic [c_rpt_w-1:0]     c_rpt_next  = c_rpt_w'(REPEAT_PERIOD - 1);
   localparam logic [c_rpt_w-1:0]     c_rpt_one   = c_rpt_w'(1);

   logic [c_rpt_w-1:0] rpt_cnt_q, rpt_cnt_d;
   // Set once the first (REPEAT_DELAY) repeat has fired; later repeats then
   // use REPEAT_PERIOD as the interval.
   logic               rpt_after_first_q, rpt_after_first_d;
   logic               rpt_counting;

   // The counter advances only on cycles that keep the FSM in HELD; any
   // exit from HELD returns it to zero so a re-entry restarts REPEAT_DELAY.
   assign rpt_counting = (state_q == ST_HELD) && s;
   assign rpt_fire     = rpt_counting &&
                         (rpt_cnt_q == (rpt_after_first_q ? c_rpt_next : c_rpt_first));

   always_comb begin
      rpt_cnt_d         = '0;
      rpt_after_first_d = 1'b0;
      if (rpt_counting) begin
         if (rpt_fire) begin
            rpt_cnt_d         = '0;
            rpt_after_first_d = 1'b1;
         end else begin
            rpt_cnt_d         = rpt_cnt_q + c_rpt_one;
            rpt_after_first_d = rpt_after_first_q;
         end
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         rpt_cnt_q         <= '0;
         rpt_after_first_q <= 1'b0;
      end else begin
         rpt_cnt_q         <= rpt_cnt_d;
         rpt_after_first_q <= rpt_after_first_d;
      end
   end
`else
   // Feature absent: exactly one pulse per accepted press.
   assign rpt_fire = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s) begin
               state_d = ST_ARMING;
               cnt_d   = c_cnt_one;
            end else begin
               cnt_d   = '0;
            end
         end

         ST_ARMING: begin
            if (!s) begin
               // Glitch shorter than STABLE_CYCLES samples: discard.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == c_cnt_last) begin
               // Current sample is the STABLE_CYCLES-th consecutive high.
               state_d = ST_HELD;
               level_d = 1'b1;
               pulse_d = enable;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + c_cnt_one;
            end
         end

         ST_HELD: begin
            if (!s) begin
               state_d = ST_RELEASING;
               cnt_d   = c_cnt_one;
            end else if (rpt_fire) begin
               pulse_d = enable;
            end
         end

         ST_RELEASING: begin
            if (s) begin
               // Release bounce: still held, and no new press is reported.
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == c_cnt_last) begin
               state_d = ST_IDLE;
               level_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + c_cnt_one;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;
   assign level = level_q;
   assign state = state_q;

endmodule : debounce_pulse
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_pulse
// Description : Self-checking bench for debounce_pulse. A reference model
//               (run-length debounce of the delayed input) pushes the
//               expected outputs for every clock edge into a queue; a monitor
//               pops and compares on the falling edge. Directed sequences
//               check latencies, masking and mid-press clear, followed by a
//               randomized bouncing input.
//               Build with DEBOUNCE_PULSE_AUTO_REPEAT_EN to cover auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_pulse;

   localparam int STABLE = 4;
   localparam int DELAY  = 16;
   localparam int PERIOD = 4;

   logic       clock  = 1'b0;
   logic       clear  = 1'b0;
   logic       raw_in = 1'b0;
   logic       enable = 1'b1;
   logic       pulse;
   logic       level;
   logic [1:0] state;

   always #5 clock = ~clock;

   debounce_pulse #(
      .STABLE_CYCLES (STABLE),
      .REPEAT_DELAY  (DELAY),
      .REPEAT_PERIOD (PERIOD)
   ) dut (
      .clock  (clock),
      .clear  (clear),
      .raw_in (raw_in),
      .enable (enable),
      .pulse  (pulse),
      .level  (level),
      .state  (state)
   );

   typedef struct packed {
      logic       p;
      logic       l;
      logic [1:0] st;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: s is raw_in delayed by two edges; the debounced level
   // flips once STABLE consecutive samples of s disagree with it. The state
   // is then IDLE/HELD when no disagreement run is in progress and
   // ARMING/RELEASING while one is.
   // ------------------------------------------------------------------------
   bit m_d1, m_d2, m_level;
   int m_run;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
   int m_held_cycles;
`endif

   initial begin
      bit   s, p, was_held;
      obs_t e;
      forever begin
         @(posedge clock);
         if (!clear) begin
            m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
            m_held_cycles = 0;
`endif
            e = '0;
         end else begin
            s        = m_d2;
            m_d2     = m_d1;
            m_d1     = raw_in;
            was_held = m_level && (m_run == 0);
            p        = 0;
            if (s != m_level) begin
               m_run++;
               if (m_run == STABLE) begin
                  m_level = s;
                  m_run   = 0;
                  if (s) p = enable;
               end
            end else begin
               m_run = 0;
            end
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
            if (was_held && s) begin
               m_held_cycles++;
               if (m_held_cycles >= DELAY && ((m_held_cycles - DELAY) % PERIOD) == 0)
                  p = enable;
            end else begin
               m_held_cycles = 0;
            end
`else
            if (was_held) p = p; // held presses never repeat in this build
`endif
            e.p  = p;
            e.l  = m_level;
            case ({m_level, m_run != 0})
               2'b00:   e.st = 2'b00;
               2'b01:   e.st = 2'b01;
               2'b10:   e.st = 2'b10;
               default: e.st = 2'b11;
            endcase
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: compares the DUT once per cycle, away from the rising edge.
   initial begin
      obs_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!clear) e = '0; // asynchronous clear overrides immediately
            check("scoreboard {pulse,level,state}", {4'h0, pulse, level, state}, {4'h0, e});
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers: inputs change 2 time units after a rising edge, so the
   // next rising edge is "edge 1" of any sequence started by a change.
   // ------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   // Edge number (from now) on which pulse first reads high; 99 = timeout.
   task automatic pulse_latency(output int lat);
      lat = 99;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clock); #1;
         if (pulse === 1'b1) begin
            lat = e;
            break;
         end
      end
      #1;
   endtask

   // Counts pulses over n edges, recording the first pulse edge.
   task automatic count_pulses(input int n, output int cnt, output int first);
      cnt = 0; first = 0;
      for (int e = 1; e <= n; e++) begin
         @(posedge clock); #1;
         if (pulse === 1'b1) begin
            cnt++;
            if (first == 0) first = e;
         end
      end
      #1;
   endtask

   initial begin
      int lat, cnt, first, hold;
      logic [5:0] bounce;

      // ---- reset held with raw_in high ------------------------------------
      clear = 1'b0; raw_in = 1'b1; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         check("reset outputs", {4'h0, pulse, level, state}, 8'h00);
      end
      #1;
      clear = 1'b1;
      pulse_latency(lat);
      check("press latency after reset", 8'(lat), 8'd6);
      check("level/state after accept", {6'h0, state} | {7'h0, level} << 2, 8'h06);

      // ---- clean press continues held, then release -----------------------
      count_pulses(14, cnt, first);
`ifndef DEBOUNCE_PULSE_AUTO_REPEAT_EN
      check("no extra pulse while held", 8'(cnt), 8'd0);
`endif
      raw_in = 1'b0;
      lat = 99;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clock); #1;
         if (level === 1'b0) begin lat = e; break; end
      end
      #1;
      check("release latency", 8'(lat), 8'd6);
      step(4);

      // ---- bounce ----------------------------------------------------------
      bounce = 6'b101101; // applied MSB first: 1,0,1,1,0,1
      cnt = 0;
      for (int i = 5; i >= 1; i--) begin
         raw_in = bounce[i];
         @(posedge clock); #1;
         if (pulse === 1'b1) cnt++;
         #1;
      end
      raw_in = bounce[0];
      check("no pulse during bounce", 8'(cnt), 8'd0);
      pulse_latency(lat);
      check("pulse latency after final rise", 8'(lat), 8'd6);
      raw_in = 1'b0;
      step(10);

      // ---- enable mask -----------------------------------------------------
      enable = 1'b0; raw_in = 1'b1;
      count_pulses(8, cnt, first);
      check("masked press pulse count", 8'(cnt), 8'd0);
      check("masked press level", {7'h0, level}, 8'h01);
      check("masked press state", {6'h0, state}, 8'h02);
      enable = 1'b1;
      count_pulses(6, cnt, first);
      check("late enable gives no pulse", 8'(cnt), 8'd0);
      raw_in = 1'b0;
      step(10);

      // ---- clear in the middle of ARMING ----------------------------------
      raw_in = 1'b1;
      step(4);
      check("mid-arming state", {6'h0, state}, 8'h01);
      clear = 1'b0;
      #1;
      check("outputs zero on clear", {4'h0, pulse, level, state}, 8'h00);
      step(1);
      clear = 1'b1;
      pulse_latency(lat);
      check("press latency after mid clear", 8'(lat), 8'd6);
      raw_in = 1'b0;
      step(10);

      // ---- long hold: 40 cycles high ---------------------------------------
      raw_in = 1'b1;
      count_pulses(40, cnt, first);
      raw_in = 1'b0;
      count_pulses(10, hold, lat);
      cnt = cnt + hold;
      check("long hold first pulse edge", 8'(first), 8'd6);
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
      check("long hold pulse count", 8'(cnt), 8'd7);
`else
      check("long hold pulse count", 8'(cnt), 8'd1);
`endif
      step(4);

      // ---- randomized bouncing input --------------------------------------
      for (int i = 0; i < 300; i++) begin
         raw_in = 1'($urandom_range(0, 1));
         enable = ($urandom_range(0, 7) != 0);
         hold   = $urandom_range(1, 9);
         step(hold);
         if ($urandom_range(0, 39) == 0) begin
            clear = 1'b0;
            step($urandom_range(1, 2));
            clear = 1'b1;
         end
      end
      raw_in = 1'b0; enable = 1'b1;
      step(12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_debounce_pulse
`default_nettype wire
